// File: rtl/adc_serial_sequencer_if.sv
// ADC handshake and serial TX bundle
// shared by the sampling sequencer and its environment.
interface adc_serial_sequencer_if #(
  parameter int DATA_BITS = 8
);
  logic                 run;
  logic                 adc_start;
  logic                 adc_done;
  logic [DATA_BITS-1:0] adc_data;
  logic                 tx;
  logic                 busy;
  logic [15:0]          sample_cnt;
  logic                 overrun;
  logic                 timeout_err;
  logic                 clr_flags;

  modport master (
    input  run, adc_done, adc_data, clr_flags,
    output adc_start, tx, busy, sample_cnt,
    output overrun, timeout_err
  );

  modport slave (
    output run, adc_done, adc_data, clr_flags,
    input  adc_start, tx, busy, sample_cnt,
    input  overrun, timeout_err
  );
endinterface

// File: rtl/adc_serial_sequencer.sv
// Periodic ADC sampling scheduler: trigger a conversion,
// latch the word, ship it as one UART frame on tx.
module adc_serial_sequencer #(
  parameter int DATA_BITS     = 8,
  parameter int CLK_DIV       = 434,
  parameter int SAMPLE_PERIOD = 10000,
  parameter int ADC_TIMEOUT   = 255
) (
  input logic                    clk,
  input logic                    rst,
  adc_serial_sequencer_if.master bus
);
  localparam int TW = $clog2(SAMPLE_PERIOD + 1);
  localparam int BW = $clog2(CLK_DIV + 1);
  localparam int CW = $clog2(ADC_TIMEOUT + 1);
  localparam int NW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [BW-1:0] B_LAST = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_LAST = CW'(ADC_TIMEOUT - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, CONVERT, START, DATA, STOP, WAIT
  } state_t;

  state_t               state;
  logic [TW-1:0]        timer;
  logic [BW-1:0]        baud;
  logic [CW-1:0]        conv;
  logic [NW-1:0]        nbit;
  logic [DATA_BITS-1:0] shift;
  logic                 tick;
  logic                 baud_end;

  assign tick     = (state != IDLE) && (timer == T_LAST);
  assign baud_end = (baud == B_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      timer           <= '0;
      baud            <= '0;
      conv            <= '0;
      nbit            <= '0;
      shift           <= '0;
      bus.tx          <= 1'b1;
      bus.adc_start   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.sample_cnt  <= '0;
      bus.overrun     <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.adc_start <= 1'b0;

      if (bus.clr_flags) begin
        bus.overrun     <= 1'b0;
        bus.timeout_err <= 1'b0;
      end
      // a tick outside WAIT is dropped; set beats clear
      if (tick && state != WAIT)
        bus.overrun <= 1'b1;

      if (state == IDLE || tick)
        timer <= '0;
      else
        timer <= timer + 1'b1;

      unique case (state)
        IDLE: begin
          if (bus.run) begin
            state         <= CONVERT;
            bus.adc_start <= 1'b1;
            bus.busy      <= 1'b1;
            conv          <= '0;
          end
        end
        CONVERT: begin
          if (bus.adc_done) begin
            shift  <= bus.adc_data;
            baud   <= '0;
            bus.tx <= 1'b0;
            state  <= START;
          end else if (conv == C_LAST) begin
            bus.timeout_err <= 1'b1;
            state           <= WAIT;
          end else begin
            conv <= conv + 1'b1;
          end
        end
        START: begin
          if (baud_end) begin
            baud   <= '0;
            nbit   <= '0;
            bus.tx <= shift[0];
            state  <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (nbit == N_LAST) begin
              bus.tx <= 1'b1;
              state  <= STOP;
            end else begin
              shift  <= shift >> 1;
              bus.tx <= shift[1];
              nbit   <= nbit + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud           <= '0;
            bus.sample_cnt <= bus.sample_cnt + 16'd1;
            state          <= WAIT;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        WAIT: begin
          if (!bus.run) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (tick) begin
            state         <= CONVERT;
            bus.adc_start <= 1'b1;
            conv          <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.tx   <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adc_serial_sequencer.sv
// Directed bench for adc_serial_sequencer:
// framing, periodic ticks, timeout, overrun, wrap.
module tb_adc_serial_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  logic       man_done = 1'b0;
  logic [7:0] man_data = 8'h00;
  logic       auto_en = 1'b0;
  logic       auto_done = 1'b0;
  logic [7:0] auto_data = 8'h00;
  logic       auto_done_ov = 1'b0;

  adc_serial_sequencer_if bus();
  adc_serial_sequencer_if bus_ov();

  assign bus.adc_done    = man_done | auto_done;
  assign bus.adc_data    = auto_done ? auto_data : man_data;
  assign bus_ov.adc_done = auto_done_ov;
  assign bus_ov.adc_data = 8'h3C;

  adc_serial_sequencer #(
    .DATA_BITS(8), .CLK_DIV(4),
    .SAMPLE_PERIOD(100), .ADC_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.master)
  );

  adc_serial_sequencer #(
    .DATA_BITS(8), .CLK_DIV(4),
    .SAMPLE_PERIOD(30), .ADC_TIMEOUT(8)
  ) dut_ov (
    .clk(clk), .rst(rst), .bus(bus_ov.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC models: answer one cycle after the start pulse
  initial begin
    forever begin
      @(negedge clk);
      if (auto_en && bus.adc_start === 1'b1) begin
        @(negedge clk);
        auto_done = 1'b1;
        @(negedge clk);
        auto_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus_ov.adc_start === 1'b1) begin
        @(negedge clk);
        auto_done_ov = 1'b1;
        @(negedge clk);
        auto_done_ov = 1'b0;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.tx, bus.busy, bus.adc_start, bus.overrun,
         bus.timeout_err, bus.sample_cnt} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h",
        {bus.tx, bus.busy, bus.adc_start, bus.overrun,
         bus.timeout_err, bus.sample_cnt},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
    end
    total++;
    if ({bus_ov.tx, bus_ov.busy} !== 2'b10) begin
      bad++;
      $display("FAIL reset_ov got=%b want=10",
        {bus_ov.tx, bus_ov.busy});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.busy, bus.adc_start, bus.tx} !== 3'b001) begin
      bad++;
      $display("FAIL idle_hold got=%b want=001",
        {bus.busy, bus.adc_start, bus.tx});
    end
  endtask

  task automatic test_frame();
    logic [9:0] fr;
    fr = {1'b1, 8'hA5, 1'b0};
    bus.run = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.adc_start, bus.busy} !== 2'b11) begin
      bad++;
      $display("FAIL frm_start got=%b want=11",
        {bus.adc_start, bus.busy});
    end
    @(negedge clk);
    total++;
    if (bus.adc_start !== 1'b0) begin
      bad++;
      $display("FAIL frm_pulse got=%b want=0", bus.adc_start);
    end
    man_data = 8'hA5;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    man_data = 8'h00;
    bus.run  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin
        man_done = 1'b1;
        man_data = 8'hFF;
      end
      if (i == 21) begin
        man_done = 1'b0;
        man_data = 8'h00;
      end
      total++;
      if (bus.tx !== fr[i/4]) begin
        bad++;
        $display("FAIL frm_tx[%0d] got=%b want=%b",
          i, bus.tx, fr[i/4]);
      end
      @(negedge clk);
    end
    total++;
    if ({bus.busy, bus.tx, bus.sample_cnt} !==
        {1'b1, 1'b1, 16'd1}) begin
      bad++;
      $display("FAIL frm_end got=%h want=%h",
        {bus.busy, bus.tx, bus.sample_cnt},
        {1'b1, 1'b1, 16'd1});
    end
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL frm_idle busy=%b want=0", bus.busy);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    bus.run = 1'b1;
    n = 0;
    while (bus.timeout_err !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (bus.adc_start !== 1'b1 && n < 150) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.adc_start !== 1'b1) begin
      bad++;
      $display("FAIL mr_start got=%b want=1", bus.adc_start);
    end
    @(negedge clk);
    man_data = 8'h00;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if ({bus.tx, bus.timeout_err, bus.sample_cnt} !==
        {1'b0, 1'b1, 16'd1}) begin
      bad++;
      $display("FAIL mr_pre got=%h want=%h",
        {bus.tx, bus.timeout_err, bus.sample_cnt},
        {1'b0, 1'b1, 16'd1});
    end
    rst = 1'b1;
    bus.run = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.tx, bus.busy, bus.adc_start, bus.overrun,
         bus.timeout_err, bus.sample_cnt} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL mr_reset got=%h want=%h",
        {bus.tx, bus.busy, bus.adc_start, bus.overrun,
         bus.timeout_err, bus.sample_cnt},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if ({bus.tx, bus.busy} !== 2'b10) begin
      bad++;
      $display("FAIL mr_after got=%b want=10",
        {bus.tx, bus.busy});
    end
  endtask

  task automatic test_periodic();
    int st[5];
    int k;
    int n;
    k = 0;
    n = 0;
    auto_data = 8'h5A;
    auto_en   = 1'b1;
    bus.run   = 1'b1;
    while (k < 5 && n < 700) begin
      @(negedge clk);
      n++;
      if (bus.adc_start === 1'b1) begin
        st[k] = cyc;
        k++;
        if (k == 5) bus.run = 1'b0;
      end
    end
    total++;
    if (k != 5) begin
      bad++;
      $display("FAIL per_starts got=%0d want=5", k);
    end
    for (int i = 1; i < k; i++) begin
      total++;
      if (st[i] - st[i-1] != 100) begin
        bad++;
        $display("FAIL per_gap[%0d] got=%0d want=100",
          i, st[i] - st[i-1]);
      end
    end
    n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if ({bus.busy, bus.overrun, bus.sample_cnt} !==
        {1'b0, 1'b0, 16'd5}) begin
      bad++;
      $display("FAIL per_end got=%h want=%h",
        {bus.busy, bus.overrun, bus.sample_cnt},
        {1'b0, 1'b0, 16'd5});
    end
    auto_en = 1'b0;
  endtask

  task automatic test_timeout();
    logic tx_low;
    tx_low = 1'b0;
    bus.run = 1'b1;
    @(negedge clk);
    total++;
    if (bus.adc_start !== 1'b1) begin
      bad++;
      $display("FAIL to_start got=%b want=1", bus.adc_start);
    end
    repeat (7) @(negedge clk);
    total++;
    if (bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL to_early got=%b want=0", bus.timeout_err);
    end
    @(negedge clk);
    total++;
    if ({bus.timeout_err, bus.tx, bus.busy} !== 3'b111) begin
      bad++;
      $display("FAIL to_flag got=%b want=111",
        {bus.timeout_err, bus.tx, bus.busy});
    end
    for (int i = 0; i < 91; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) tx_low = 1'b1;
    end
    total++;
    if ({tx_low, bus.adc_start} !== 2'b00) begin
      bad++;
      $display("FAIL to_quiet got=%b want=00",
        {tx_low, bus.adc_start});
    end
    @(negedge clk);
    total++;
    if (bus.adc_start !== 1'b1) begin
      bad++;
      $display("FAIL to_retick got=%b want=1", bus.adc_start);
    end
    bus.run = 1'b0;
    bus.clr_flags = 1'b1;
    @(negedge clk);
    bus.clr_flags = 1'b0;
    total++;
    if (bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL to_clr got=%b want=0", bus.timeout_err);
    end
    repeat (7) @(negedge clk);
    total++;
    if (bus.timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL to_again got=%b want=1", bus.timeout_err);
    end
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL to_idle busy=%b want=0", bus.busy);
    end
  endtask

  task automatic test_overrun();
    int         n;
    logic [9:0] got;
    logic       seen;
    bus_ov.run = 1'b1;
    for (int f = 0; f < 3; f++) begin
      n = 0;
      while (bus_ov.tx !== 1'b0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      total++;
      if (bus_ov.tx !== 1'b0) begin
        bad++;
        $display("FAIL ov_sof[%0d] tx=%b want=0", f, bus_ov.tx);
      end
      got = '0;
      for (int k = 0; k < 40; k++) begin
        if (k % 4 == 1) got[k/4] = bus_ov.tx;
        if (f == 1 && k == 27) bus_ov.clr_flags = 1'b1;
        if (f == 1 && k == 28) begin
          bus_ov.clr_flags = 1'b0;
          total++;
          if (bus_ov.overrun !== 1'b1) begin
            bad++;
            $display("FAIL ov_setwins got=%b want=1",
              bus_ov.overrun);
          end
        end
        if (f == 2 && k == 10) bus_ov.run = 1'b0;
        @(negedge clk);
      end
      total++;
      if (got !== {1'b1, 8'h3C, 1'b0}) begin
        bad++;
        $display("FAIL ov_frame[%0d] got=%b want=%b",
          f, got, {1'b1, 8'h3C, 1'b0});
      end
      total++;
      if (bus_ov.overrun !== 1'b1) begin
        bad++;
        $display("FAIL ov_flag[%0d] got=%b want=1",
          f, bus_ov.overrun);
      end
      if (f == 0) begin
        bus_ov.clr_flags = 1'b1;
        @(negedge clk);
        bus_ov.clr_flags = 1'b0;
        total++;
        if (bus_ov.overrun !== 1'b0) begin
          bad++;
          $display("FAIL ov_clr got=%b want=0", bus_ov.overrun);
        end
      end
    end
    n = 0;
    while (bus_ov.busy !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_ov.adc_start !== 1'b0) seen = 1'b1;
    end
    total++;
    if ({bus_ov.busy, seen, bus_ov.sample_cnt} !==
        {1'b0, 1'b0, 16'd3}) begin
      bad++;
      $display("FAIL ov_stop got=%h want=%h",
        {bus_ov.busy, seen, bus_ov.sample_cnt},
        {1'b0, 1'b0, 16'd3});
    end
  endtask

  task automatic test_wrap();
    int n;
    @(negedge clk);
    force bus.sample_cnt = 16'hFFFF;
    @(negedge clk);
    release bus.sample_cnt;
    #1;
    total++;
    if (bus.sample_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_load got=%h want=ffff",
        bus.sample_cnt);
    end
    @(negedge clk);
    auto_data = 8'h11;
    auto_en   = 1'b1;
    bus.run   = 1'b1;
    repeat (50) @(negedge clk);
    total++;
    if ({bus.busy, bus.sample_cnt} !== {1'b1, 16'h0000}) begin
      bad++;
      $display("FAIL wrap_cnt got=%h want=%h",
        {bus.busy, bus.sample_cnt}, {1'b1, 16'h0000});
    end
    bus.run = 1'b0;
    n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL wrap_idle busy=%b want=0", bus.busy);
    end
    auto_en = 1'b0;
  endtask

  initial begin
    bus.run          = 1'b0;
    bus.clr_flags    = 1'b0;
    bus_ov.run       = 1'b0;
    bus_ov.clr_flags = 1'b0;
    test_reset();
    test_frame();
    test_mid_reset();
    test_periodic();
    test_timeout();
    test_overrun();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
